pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: stage k adds one WIDTH/STAGES-bit slice,
// and one global advance enable freezes the whole pipeline under backpressure.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int SLICE = WIDTH / STAGES;

  // Stage k registers: operands (B already inverted for subtract), sum with slices
  // 0..k final, carry out of slice k, and the valid bit.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_i  [STAGES];
  logic [WIDTH-1:0] b_i  [STAGES];
  logic [WIDTH-1:0] s_i  [STAGES];
  logic             c_i  [STAGES];
  logic             v_i  [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_nx [STAGES];
  logic [SLICE:0]   slice_sum;
  logic             adv;

  assign adv       = !(valid_out && !ready_in);
  assign ready_out = adv;

  always_comb begin
    // NOTE: every variable written here gets a value on every pass before it is read, so no latch is inferred.
    slice_sum = '0;
    a_i[0]    = a_in;
    b_i[0]    = sub_in ? ~b_in : b_in;
    s_i[0]    = '0;
    c_i[0]    = sub_in ? !c_in : c_in;
    v_i[0]    = valid_in;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_i[k][k*SLICE +: SLICE]}
                + {1'b0, b_i[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, c_i[k]};
      s_nx[k]                  = s_i[k];
      s_nx[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      c_nx[k]                  = slice_sum[SLICE];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the data registers are cleared as well, because the last stage drives the result outputs directly.
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      // NOTE: non-blocking updates make every stage take its predecessor's pre-edge value.
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_i[k];
      end
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and the MSB operand bits.
  assign sum_out   = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign valid_out = v_q[STAGES-1];
  assign ovf_out   = c_q[STAGES-1] ^ a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                   ^ s_q[STAGES-1][WIDTH-1];

endmodule
